// File: rtl/debug_frame_tx.sv
// debug_frame_tx: snapshots seven CPU debug bytes and sends them as one
// 8N1 UART burst: sync byte, seven data bytes, XOR checksum.
module debug_frame_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d, bit_nx;
  logic [3:0]    byte_q, byte_d;
  logic [55:0]   snap_q;
  logic [7:0]    chk_q;
  logic [7:0]    cur;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          take;
  logic          tmr_end;

  assign tmr_end = (tmr_q == TMAX);
  assign bit_nx  = bit_q + 3'd1;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_comb begin
    unique case (byte_q)
      4'd0:    cur = SYNC_BYTE;
      4'd1:    cur = snap_q[7:0];
      4'd2:    cur = snap_q[15:8];
      4'd3:    cur = snap_q[23:16];
      4'd4:    cur = snap_q[31:24];
      4'd5:    cur = snap_q[39:32];
      4'd6:    cur = snap_q[47:40];
      4'd7:    cur = snap_q[55:48];
      default: cur = chk_q;
    endcase
  end

  // tx_d is the line level for the cycle after the edge, so tx stays a flop
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          take    = 1'b1;
          state_d = START;
          tmr_d   = '0;
          byte_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (tmr_end) begin
          state_d = DATA;
          tmr_d   = '0;
          bit_d   = '0;
          tx_d    = cur[0];
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DATA: begin
        if (tmr_end) begin
          tmr_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nx;
            tx_d  = cur[bit_nx];
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      STOP: begin
        if (tmr_end) begin
          tmr_d = '0;
          if (byte_q < 4'd8) begin
            byte_d  = byte_q + 4'd1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
      chk_q  <= '0;
    end else if (take) begin
      snap_q <= {debug_port7, debug_port6, debug_port5, debug_port4,
                 debug_port3, debug_port2, debug_port1};
      chk_q  <= debug_port1 ^ debug_port2 ^ debug_port3 ^ debug_port4 ^
                debug_port5 ^ debug_port6 ^ debug_port7;
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// tb_debug_frame_tx: three instances (4, 2, 434 clocks per bit) checked
// every cycle against a bit-stream model and a bench UART decoder.
module tb_debug_frame_tx;

  localparam int C0 = 4;
  localparam int C1 = 2;
  localparam int C2 = 434;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [3];
  logic       st     [3];
  logic [7:0] prt    [3][7];
  logic       tx_w   [3];
  logic       busy_w [3];
  logic       done_w [3];

  debug_frame_tx #(.CLKS_PER_BIT(C0), .SYNC_BYTE(8'hA5)) u0 (
    .clk(clk), .reset(rst[0]), .start(st[0]),
    .debug_port1(prt[0][0]), .debug_port2(prt[0][1]),
    .debug_port3(prt[0][2]), .debug_port4(prt[0][3]),
    .debug_port5(prt[0][4]), .debug_port6(prt[0][5]),
    .debug_port7(prt[0][6]),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  debug_frame_tx #(.CLKS_PER_BIT(C1), .SYNC_BYTE(8'hA5)) u1 (
    .clk(clk), .reset(rst[1]), .start(st[1]),
    .debug_port1(prt[1][0]), .debug_port2(prt[1][1]),
    .debug_port3(prt[1][2]), .debug_port4(prt[1][3]),
    .debug_port5(prt[1][4]), .debug_port6(prt[1][5]),
    .debug_port7(prt[1][6]),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  debug_frame_tx #(.CLKS_PER_BIT(C2), .SYNC_BYTE(8'hA5)) u2 (
    .clk(clk), .reset(rst[2]), .start(st[2]),
    .debug_port1(prt[2][0]), .debug_port2(prt[2][1]),
    .debug_port3(prt[2][2]), .debug_port4(prt[2][3]),
    .debug_port5(prt[2][4]), .debug_port6(prt[2][5]),
    .debug_port7(prt[2][6]),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          act   [3];
  int          k     [3];
  logic [89:0] strm  [3];
  logic        etx   [3];
  logic        ebusy [3];
  logic        edone [3];
  bit          rxon  [3];
  int          ph    [3];
  logic [7:0]  sh    [3];
  logic [7:0]  rxb   [3][128];
  int          rxn   [3];
  int          run   [3];
  int          last_run [3];
  int          dcnt  [3];

  function automatic int cpb(int g);
    return (g == 0) ? C0 : ((g == 1) ? C1 : C2);
  endfunction

  function automatic logic [89:0] mk_stream(int g);
    logic [7:0]  b [9];
    logic [89:0] s;
    b[0] = 8'hA5;
    b[8] = 8'h00;
    for (int i = 0; i < 7; i++) begin
      b[i+1] = prt[g][i];
      b[8]   = b[8] ^ prt[g][i];
    end
    for (int j = 0; j < 9; j++) begin
      s[j*10] = 1'b0;
      for (int i = 0; i < 8; i++) s[j*10+1+i] = b[j][i];
      s[j*10+9] = 1'b1;
    end
    return s;
  endfunction

  task automatic chk(string nm, int g, logic [31:0] a, logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, g, $time, a, e);
    end
  endtask

  // per-cycle compare, UART decode and next-cycle prediction
  initial begin
    int c;
    int idx;
    for (int g = 0; g < 3; g++) begin
      act[g] = 0; k[g] = 0; etx[g] = 1'b1; ebusy[g] = 1'b0; edone[g] = 1'b0;
      rxon[g] = 0; ph[g] = 0; rxn[g] = 0; run[g] = 0; last_run[g] = 0;
      dcnt[g] = 0; sh[g] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        c = cpb(g);
        if (rst[g]) begin
          act[g] = 0; etx[g] = 1'b1; ebusy[g] = 1'b0; edone[g] = 1'b0;
        end
        chk("tx", g, tx_w[g], etx[g]);
        chk("busy", g, busy_w[g], ebusy[g]);
        chk("done", g, done_w[g], edone[g]);
        if (done_w[g]) dcnt[g]++;
        if (busy_w[g]) run[g]++;
        else begin
          if (run[g] > 0) last_run[g] = run[g];
          run[g] = 0;
        end
        if (rst[g]) rxon[g] = 0;
        else if (rxon[g]) begin
          ph[g]++;
          if (ph[g] >= c/2 && ((ph[g] - c/2) % c) == 0) begin
            idx = (ph[g] - c/2) / c;
            if (idx >= 1 && idx <= 8) sh[g][idx-1] = tx_w[g];
            if (idx == 9) begin
              chk("rx_stop", g, tx_w[g], 1);
              if (rxn[g] < 128) rxb[g][rxn[g]] = sh[g];
              rxn[g]++;
              rxon[g] = 0;
            end
          end
        end else if (tx_w[g] == 1'b0) begin
          rxon[g] = 1; ph[g] = 0;
        end
        if (!rst[g]) begin
          if (!act[g]) begin
            edone[g] = 1'b0;
            if (st[g]) begin
              act[g] = 1; k[g] = 0; strm[g] = mk_stream(g);
              etx[g] = strm[g][0]; ebusy[g] = 1'b1;
            end else begin
              etx[g] = 1'b1; ebusy[g] = 1'b0;
            end
          end else begin
            k[g]++;
            if (k[g] == 90*c) begin
              act[g] = 0; etx[g] = 1'b1; ebusy[g] = 1'b0; edone[g] = 1'b1;
            end else begin
              etx[g] = strm[g][k[g]/c]; ebusy[g] = 1'b1; edone[g] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fire(int g);
    st[g] = 1'b1;
    tick(1);
    st[g] = 1'b0;
  endtask

  task automatic wait_done(int g, int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_w[g]) begin
        ok = 1;
        break;
      end
    end
    chk("done_seen", g, ok, 1);
  endtask

  task automatic set_ports(int g, input logic [7:0] v [7]);
    for (int i = 0; i < 7; i++) prt[g][i] = v[i];
  endtask

  task automatic check_frame(int g, int base, input logic [7:0] e [9]);
    for (int i = 0; i < 9; i++)
      chk("rx_byte", g, (base+i < 128) ? rxb[g][base+i] : 8'hxx, e[i]);
  endtask

  initial begin
    logic [7:0] pa [7];
    logic [7:0] pb [7];
    logic [7:0] pff [7];
    logic [7:0] ea [9];
    logic [7:0] eb [9];
    logic [7:0] e1 [9];
    logic [7:0] e2 [9];
    int base;
    int base2;
    int d0;
    pa  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    ea  = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h7F};
    pb  = '{8'h3C, 8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h81, 8'h7E};
    eb  = '{8'hA5, 8'h3C, 8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'hA5};
    pff = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1;
      st[g]  = 1'b0;
      for (int i = 0; i < 7; i++) prt[g][i] = 8'h00;
    end
    tick(3);
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;

    tick(100);
    chk("idle_tx", 0, tx_w[0], 1);
    chk("idle_busy", 0, busy_w[0], 0);
    chk("idle_done_cnt", 0, dcnt[0], 0);

    set_ports(0, pa);
    base = rxn[0]; d0 = dcnt[0];
    fire(0);
    wait_done(0, 400);
    @(negedge clk);
    chk("busy_len", 0, last_run[0], 360);
    chk("done_pulses", 0, dcnt[0] - d0, 1);
    chk("rx_count", 0, rxn[0] - base, 9);
    check_frame(0, base, ea);
    tick(5);

    base = rxn[0];
    fire(0);
    tick(19);
    set_ports(0, pff);
    wait_done(0, 400);
    @(negedge clk);
    chk("snap_count", 0, rxn[0] - base, 9);
    check_frame(0, base, ea);
    tick(5);

    set_ports(0, pa);
    base = rxn[0]; d0 = dcnt[0];
    fire(0);
    tick(49);
    st[0] = 1'b1; tick(1); st[0] = 1'b0;
    tick(149);
    st[0] = 1'b1; tick(1); st[0] = 1'b0;
    tick(1);
    st[0] = 1'b1;
    wait_done(0, 400);
    @(negedge clk);
    chk("restart_busy", 0, busy_w[0], 1);
    chk("one_frame", 0, dcnt[0] - d0, 1);
    tick(1);
    st[0] = 1'b0;
    wait_done(0, 400);
    @(negedge clk);
    chk("two_frames", 0, dcnt[0] - d0, 2);
    chk("b2b_count", 0, rxn[0] - base, 18);
    check_frame(0, base, ea);
    check_frame(0, base + 9, ea);
    tick(5);

    d0 = dcnt[0];
    fire(0);
    tick(149);
    rst[0] = 1'b1;
    #1;
    chk("rst_tx", 0, tx_w[0], 1);
    chk("rst_busy", 0, busy_w[0], 0);
    tick(3);
    rst[0] = 1'b0;
    tick(5);
    chk("rst_no_done", 0, dcnt[0] - d0, 0);
    set_ports(0, pb);
    base = rxn[0];
    fire(0);
    wait_done(0, 400);
    @(negedge clk);
    chk("post_rst_count", 0, rxn[0] - base, 9);
    check_frame(0, base, eb);
    tick(2);

    e1[0] = 8'hA5; e1[8] = 8'h00;
    e2[0] = 8'hA5; e2[8] = 8'h00;
    for (int i = 0; i < 7; i++) begin
      prt[1][i] = 8'($urandom_range(0, 255));
      prt[2][i] = 8'($urandom_range(0, 255));
      e1[i+1] = prt[1][i]; e1[8] = e1[8] ^ prt[1][i];
      e2[i+1] = prt[2][i]; e2[8] = e2[8] ^ prt[2][i];
    end
    base = rxn[1]; base2 = rxn[2];
    st[1] = 1'b1; st[2] = 1'b1;
    tick(1);
    st[1] = 1'b0; st[2] = 1'b0;
    wait_done(1, 300);
    wait_done(2, 90*C2 + 100);
    @(negedge clk);
    chk("busy_len", 1, last_run[1], 180);
    chk("busy_len", 2, last_run[2], 39060);
    chk("rx_count", 1, rxn[1] - base, 9);
    chk("rx_count", 2, rxn[2] - base2, 9);
    check_frame(1, base, e1);
    check_frame(2, base2, e2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
